// File: rtl/res_collect.sv
// Result collection buffer: assembles a streamed product matrix into a flat bus,
// overwriting or accumulating element-wise, and flags completion of each pass.
module res_collect #(
  parameter  int BITS  = 8,
  parameter  int N     = 8,
  parameter  int WIDTH = 4,
  localparam int W     = N * N / WIDTH,
  localparam int WW    = $clog2(W + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_acc,
  input  logic                      i_clear,
  input  logic                      i_in_valid,
  input  logic [WIDTH*BITS-1:0]     i_in_data,
  output logic                      o_in_ready,
  output logic [N*N*BITS-1:0]       o_all,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [WW-1:0]             o_words
);

  localparam int WB = WIDTH * BITS;
  localparam int PW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t          r_state;
  logic            r_acc;
  logic [WW-1:0]   r_words;
  logic [WB-1:0]   r_mem [W];

  logic [PW-1:0]   w_idx;
  logic [WB-1:0]   w_sum;
  logic [WB-1:0]   w_next;
  logic            w_accept;

  // The word counter doubles as the write pointer; it never wraps within a pass.
  assign w_idx      = r_words[PW-1:0];
  assign o_in_ready = (r_state == S_FILL) && !i_start && !i_clear;
  assign w_accept   = i_in_valid && o_in_ready;
  assign o_busy     = (r_state == S_FILL);
  assign o_done     = (r_state == S_DONE);
  assign o_words    = r_words;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < WIDTH; j++) begin
      // Each element wraps independently; no carry crosses element boundaries.
      w_sum[j*BITS +: BITS] = r_mem[w_idx][j*BITS +: BITS] + i_in_data[j*BITS +: BITS];
    end
  end

  assign w_next = r_acc ? w_sum : i_in_data;

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_acc   <= 1'b0;
      r_words <= '0;
      // NOTE: the storage array is reset deliberately: the read window must show zeros after rst/clear.
      for (int k = 0; k < W; k++) r_mem[k] <= '0;
    end else if (i_clear) begin
      r_state <= S_IDLE;
      r_words <= '0;
      for (int k = 0; k < W; k++) r_mem[k] <= '0;
    end else if (i_start) begin
      r_state <= S_FILL;
      r_acc   <= i_acc;
      r_words <= '0;
    end else if (w_accept) begin
      r_mem[w_idx] <= w_next;
      r_words      <= r_words + WW'(1);
      if (r_words == WW'(W - 1)) r_state <= S_DONE;
    end
  end

  for (genvar k = 0; k < W; k++) begin : g_all
    assign o_all[k*WB +: WB] = r_mem[k];
  end

endmodule

// File: doc/res_collect.md
# res_collect

Result collection buffer feeding the address-mapped result read window of the Winograd multiplier. It accepts the product matrix from the compute engine as a stream of WIDTH-element words, assembles it into the flat N*N*BITS result bus consumed by the read window, and flags completion. It can overwrite the stored matrix or accumulate into it element-wise, so tiled partial products can be summed without host involvement.

## Interface
- BITS, 8: element width in bits.
- N, 8: matrix dimension; the matrix holds N*N elements.
- WIDTH, 4: elements per input word; N*N must be divisible by WIDTH. W = N*N/WIDTH words per matrix.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  arm a new collection pass; sampled every cycle.
- acc  in  1  pass mode, latched when start is accepted: 0 = overwrite, 1 = accumulate.
- clear  in  1  zero the whole matrix and return to IDLE.
- in_valid  in  1  in_data holds a valid word.
- in_data  in  WIDTH*BITS  one word; element j occupies bits [BITS*(j+1)-1 : BITS*j].
- in_ready  out  1  the block accepts a word this cycle.
- all  out  N*N*BITS  stored matrix; word k occupies bits [WIDTH*BITS*(k+1)-1 : WIDTH*BITS*k].
- busy  out  1  the block is in FILL.
- done  out  1  a full pass completed; held until start, clear or rst.
- words  out  clog2(W+1)  number of words accepted in the current pass.

## Operation
- States: IDLE, FILL, DONE.
- Transfer: a word is accepted when in_valid and in_ready are both high. in_ready = (state == FILL) and no start or clear in the same cycle.
- IDLE/DONE to FILL on start. The word pointer and `words` clear to 0, the mode latches from acc, and done drops. `all` is not cleared by start.
- FILL on an accepted word: word[ptr] becomes in_data when the mode is overwrite. When the mode is accumulate, each element becomes old+new mod 2^BITS, computed per element with no carry between elements and no saturation. ptr and `words` then increment.
- FILL to DONE on the accept of word W-1. ptr does not wrap. No further words are accepted until the next start.
- start while in FILL restarts the pass: the pointer returns to 0 and the mode is re-latched. Words already written stay in `all`.
- clear in any state: `all` becomes 0 and the block goes to IDLE with done=0 and `words`=0. clear has priority over start. clear and start in the same cycle end in IDLE.
- Priority, highest first: rst, clear, start, data accept.
- in_valid outside FILL is ignored and nothing is written.

## Timing
- Reset values: state=IDLE, all=0, in_ready=0, busy=0, done=0, words=0, latched mode=overwrite.
- in_ready, busy and done are decoded from registered state. in_ready additionally gates combinationally on start and clear.
- Latency: the new value appears on `all` one cycle after the accept edge. `words` increments on the same edge.
- done rises on the edge that accepts word W-1. in_ready is low from the next cycle.
- Back-to-back words are accepted at one per cycle. A full pass takes exactly W accepting cycles after start.
- start to the first possible accept: the cycle after start is registered.
- rst mid-pass discards the pass and zeroes `all`.

## Test plan
Use defaults: BITS=8, N=8, WIDTH=4, W=16.
- Overwrite fill: start with acc=0, then 16 consecutive words, word k = {4{8'(k)}}. Required: all[32k+31:32k] = {4{k}}, done=1 after the 16th accept, in_ready=0 afterwards, words=16.
- Accumulate wrap: after a fill with every element 8'hF0, start with acc=1 and feed 16 words of 8'h20 per element. Required: every element = 8'h10, with neighbouring elements unaffected by any carry.
- Stall tolerance: in FILL, toggle in_valid randomly over 40 cycles carrying 16 valid words. Required: identical result to back-to-back feeding, and only valid cycles advance `words`.
- Restart mid-pass: accept 5 words, assert start with a word on in_data in the same cycle. Required: that word is not written, words=0, and the next accept lands in word 0.
- clear vs start: assert clear and start together while in DONE. Required: all=0, state IDLE, done=0, busy=0.
- Reset mid-pass: assert rst after 9 accepts. Required: all outputs at their reset values next cycle, and in_valid is ignored until start.
